// File: rtl/mips_regfile_write_arbiter.sv
// Write-port arbiter for the MIPS register file: picks one writeback source per
// cycle (round-robin or fixed priority) and stages it for the write port.
module mips_regfile_write_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_reg,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic                    write_enable,
  output logic [4:0]              write_register,
  output logic [31:0]             write_data,
  output logic [31:0]             pending_mask,
  output logic [2:0]              grant_idx
);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [2:0]         r_last;
  logic               r_we;
  logic [4:0]         r_wreg;
  logic [31:0]        r_wdata;
  logic [2:0]         r_gidx;
  logic [31:0]        r_pend;

  logic               w_found;
  logic [2:0]         w_winner;
  int                 w_idx;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_onehot;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_transfer;
  logic [4:0]         w_sel_reg;
  logic [31:0]        w_sel_data;

  // Grant search: rotate from the slot after the last winner, or scan from index 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 0;
    w_cand   = {NUM_REQ{1'b0}};
    w_onehot = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ROUND_ROBIN) begin
        w_idx = (int'(r_last) + 1 + k) % NUM_REQ;
      end else begin
        w_idx = k;
      end
      w_cand = ONE_HOT0 << w_idx;
      if (!w_found && (|(req_valid & w_cand))) begin
        w_found  = 1'b1;
        w_winner = 3'(w_idx);
        w_onehot = w_cand;
      end else begin
        w_found  = w_found;
      end
    end
    if (w_found && !hold && !reset) begin
      w_ready = w_onehot;
    end else begin
      w_ready = {NUM_REQ{1'b0}};
    end
    w_transfer = |w_ready;
    w_sel_reg  = 5'(req_reg >> (5 * int'(w_winner)));
    w_sel_data = 32'(req_data >> (32 * int'(w_winner)));
  end

  // Output stage and round-robin pointer; a register-0 write is accepted but never strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= 32'd0;
      r_gidx  <= 3'd0;
      r_pend  <= 32'd0;
      r_last  <= 3'(NUM_REQ - 1);
    end else if (w_transfer) begin
      r_we    <= (w_sel_reg != 5'd0);
      r_wreg  <= w_sel_reg;
      r_wdata <= w_sel_data;
      r_gidx  <= w_winner;
      r_pend  <= (w_sel_reg != 5'd0) ? (32'd1 << w_sel_reg) : 32'd0;
      r_last  <= w_winner;
    end else begin
      r_we    <= 1'b0;
      r_pend  <= 32'd0;
    end
  end

  assign req_ready      = w_ready;
  assign write_enable   = r_we;
  assign write_register = r_wreg;
  assign write_data     = r_wdata;
  assign grant_idx      = r_gidx;
  assign pending_mask   = r_pend;

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter share stimulus;
// a per-cycle reference model queues expectations that a negedge monitor checks.
module tb_mips_regfile_write_arbiter;

  localparam int N = 3;

  logic            clk;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_reg;
  logic [N*32-1:0] req_data;

  logic [N-1:0]    rdy   [2];
  logic            we    [2];
  logic [4:0]      wreg  [2];
  logic [31:0]     wdata [2];
  logic [31:0]     pend  [2];
  logic [2:0]      gidx  [2];

  mips_regfile_write_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_reg(req_reg), .req_data(req_data), .write_enable(we[0]), .write_register(wreg[0]),
    .write_data(wdata[0]), .pending_mask(pend[0]), .grant_idx(gidx[0]));

  mips_regfile_write_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_reg(req_reg), .req_data(req_data), .write_enable(we[1]), .write_register(wreg[1]),
    .write_data(wdata[1]), .pending_mask(pend[1]), .grant_idx(gidx[1]));

  typedef struct packed {
    int                  cyc;
    logic [1:0][N-1:0]   rdy;
    logic [1:0]          we;
    logic [1:0][4:0]     wreg;
    logic [1:0][31:0]    wdata;
    logic [1:0][31:0]    pend;
    logic [1:0][2:0]     gidx;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] dut_rf [2][32];

  // Reference state: what each arbiter has staged, plus its last winner.
  int          m_last [2];
  logic        m_we   [2];
  logic [4:0]  m_reg  [2];
  logic [31:0] m_data [2];
  logic [2:0]  m_gidx [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int m, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", name, m, cyc, got, exp);
    end
  endtask

  // Winner by rule: round-robin = valid index at the smallest forward distance from last+1.
  function automatic int winner(input int m, input logic [N-1:0] v);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (m == 1) begin
          if (best < 0) best = i;
        end else begin
          int d = (i - m_last[m] - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    return best;
  endfunction

  task automatic step(input logic rst_i, input logic hold_i, input logic [N-1:0] v,
                      input logic [N*5-1:0] r, input logic [N*32-1:0] d);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    reset = rst_i; hold = hold_i; req_valid = v; req_reg = r; req_data = d;
    e = '0;
    e.cyc = cyc;
    for (int m = 0; m < 2; m++) begin
      if (rst_i) begin
        m_last[m] = N - 1; m_we[m] = 1'b0; m_reg[m] = 5'd0; m_data[m] = 32'd0; m_gidx[m] = 3'd0;
      end
      e.we[m]    = m_we[m];
      e.wreg[m]  = m_reg[m];
      e.wdata[m] = m_data[m];
      e.gidx[m]  = m_gidx[m];
      e.pend[m]  = m_we[m] ? (32'd1 << m_reg[m]) : 32'd0;
      w = winner(m, v);
      if (!rst_i && !hold_i && w >= 0) begin
        e.rdy[m]    = 3'd1 << w;
        m_reg[m]    = r[w*5 +: 5];
        m_data[m]   = d[w*32 +: 32];
        m_gidx[m]   = 3'(w);
        m_we[m]     = (r[w*5 +: 5] != 5'd0);
        m_last[m]   = w;
      end else begin
        m_we[m] = 1'b0;
      end
    end
    q.push_back(e);
  endtask

  // Monitor: compare everything each arbiter presents against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      for (int m = 0; m < 2; m++) begin
        chk("req_ready",      m, 32'(rdy[m]),  32'(e.rdy[m]));
        chk("write_enable",   m, 32'(we[m]),   32'(e.we[m]));
        chk("write_register", m, 32'(wreg[m]), 32'(e.wreg[m]));
        chk("write_data",     m, wdata[m],     e.wdata[m]);
        chk("grant_idx",      m, 32'(gidx[m]), 32'(e.gidx[m]));
        chk("pending_mask",   m, pend[m],      e.pend[m]);
        if (we[m] === 1'b1) dut_rf[m][wreg[m]] = wdata[m];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog dut=0 got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 15'd0, 96'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
    step(1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = 3'b000; req_reg = 15'd0; req_data = 96'd0;
    for (int m = 0; m < 2; m++) for (int r = 0; r < 32; r++) dut_rf[m][r] = 32'd0;

    // Single write to reg 8
    do_reset();
    step(1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'h0000_00AA});
    idle(1);

    // All three valid for six cycles
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h333, 32'h222, 32'h111});
    idle(1);

    // Register-0 write is accepted without a strobe
    do_reset();
    step(1'b0, 1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
    idle(1);

    // Same destination from two requesters: later grant wins
    do_reset();
    step(1'b0, 1'b0, 3'b101, {5'd5, 5'd0, 5'd5}, {32'h22, 32'd0, 32'h11});
    step(1'b0, 1'b0, 3'b100, {5'd5, 5'd0, 5'd5}, {32'h22, 32'd0, 32'h11});
    idle(2);
    for (int m = 0; m < 2; m++) chk("rf_reg5", m, dut_rf[m][5], 32'h22);

    // Hold freezes grants and the pointer
    do_reset();
    step(1'b0, 1'b0, 3'b001, {5'd9, 5'd7, 5'd6}, {32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 3'b110, {5'd9, 5'd7, 5'd6}, {32'h3, 32'h2, 32'h1});
    step(1'b0, 1'b0, 3'b110, {5'd9, 5'd7, 5'd6}, {32'h3, 32'h2, 32'h1});
    idle(1);

    // Reset while a write is staged, then all valid again
    do_reset();
    step(1'b0, 1'b0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA});
    step(1'b0, 1'b0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA});
    step(1'b1, 1'b0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA});
    step(1'b0, 1'b0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA});
    step(1'b0, 1'b0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC, 32'hB, 32'hA});
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [N*5-1:0]  rr;
      logic [N*32-1:0] dd;
      rr = 15'($urandom());
      dd = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), 3'($urandom()), rr, dd);
    end
    idle(1);
    @(negedge clk);
    #1;

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain dut=0 got=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_regfile_write_arbiter.md
Name: mips_regfile_write_arbiter

Overview:
Shares the single write port of the MIPS register file between NUM_REQ writeback sources, for example the ALU result, load data return and the link address for JAL/JALR. Each source uses a valid/ready handshake. One request is granted per cycle, registered, and presented to the register file's write_enable/write_register/write_data inputs one cycle later. The block also exports a pending-write mask for the hazard logic.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ROUND_ROBIN, 1, 1 = round-robin grant; 0 = fixed priority with lowest index winning

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
hold  input  1  when 1, no grants this cycle (all req_ready = 0)
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant (combinational, one-hot or zero)
req_reg  input  NUM_REQ*5  packed destination register indices; requester i uses bits [5i+4:5i]
req_data  input  NUM_REQ*32  packed write data; requester i uses bits [32i+31:32i]
write_enable  output  1  register-file write strobe (registered)
write_register  output  5  register-file write index (registered)
write_data  output  32  register-file write data (registered)
pending_mask  output  32  bit r = 1 while a write to register r sits in the output stage
grant_idx  output  3  index of the requester whose write is in the output stage (registered)

Behaviour:
- Reset (asynchronous, active-high) forces:
  - write_enable = 0, write_register = 0, write_data = 0, pending_mask = 0, grant_idx = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
  - req_ready = 0 while reset is high.
- Grant selection is combinational each cycle, active when hold = 0 and reset = 0:
  - ROUND_ROBIN = 1: search indices last_grant+1, last_grant+2, … modulo NUM_REQ; the first with req_valid = 1 wins.
  - ROUND_ROBIN = 0: the lowest index with req_valid = 1 wins.
  - req_ready[winner] = 1; all other bits are 0. If no request is valid, req_ready = 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- A transfer occurs when req_valid[i] & req_ready[i]. The requester drops or changes its request on the next cycle.
- On a transfer at edge N:
  - write_register and write_data take the winner's values.
  - grant_idx = winner.
  - write_enable = 1 unless the winner's req_reg = 0. For register 0, write_enable = 0, the request is still accepted (ready = 1), and pending_mask stays 0.
  - last_grant = winner. The pointer updates only on a transfer, never on hold or idle cycles.
- With no transfer at an edge: write_enable = 0 and pending_mask = 0. write_register, write_data and grant_idx hold their last values.
- Latency: the value is visible at the register-file input in the cycle after the handshake and written at the following edge. Throughput is one write per cycle, with no bubbles between back-to-back grants.
- pending_mask = one-hot(write_register) when write_enable = 1, else 0. It is driven from registered state only.
- Two requesters targeting the same register in one cycle: only the winner is granted. The loser is granted in a later cycle, so the final register value is the later grant's data. No merging is performed.
- hold asserted mid-stream: the output stage still drains; the write granted in the previous cycle completes. No new grant occurs while hold = 1.
- Reset asserted mid-operation: the staged write is discarded immediately (write_enable drops asynchronously) and the round-robin pointer reinitialises.
- Fairness: with ROUND_ROBIN = 1, a continuously valid requester is granted within NUM_REQ cycles.

Test Plan:
1. Reset, then req_valid = 3'b001 with reg 8 and data 0x0000_00AA → req_ready = 001 in the same cycle. The next cycle shows write_enable = 1, write_register = 8, write_data = 0xAA, pending_mask = 0x0000_0100, grant_idx = 0.
2. ROUND_ROBIN = 1, all three valid for 6 cycles (regs 1/2/3) → grants are 0,1,2,0,1,2 and write_register sequence is 1,2,3,1,2,3 with no idle cycle. With ROUND_ROBIN = 0 and the same stimulus → requester 0 is granted all 6 cycles.
3. Requester 1 valid with reg 0 and data 0xDEAD_BEEF → req_ready[1] = 1; the next cycle write_enable = 0 and pending_mask = 0.
4. Requesters 0 and 2 both target reg 5 (data 0x11 and 0x22) after reset → 0x11 is written first and 0x22 next cycle; the register-file model reads 0x22 for reg 5.
5. hold = 1 for 3 cycles with requesters 1 and 2 valid → req_ready = 0 and the pointer is unchanged. After hold drops, requester 1 is granted first (pointer was 0).
6. Assert reset mid-cycle while write_enable = 1 → write_enable and pending_mask go to 0 before the next clock edge. After reset releases, requester 0 wins first with all requesters valid.
